// File: rtl/divider_pipe.sv
//------------------------------------------------------------------------------
// divider_pipe
//   Pipelined unsigned restoring divider with valid/ready flow control.
//   Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module divider_pipe #(
  parameter int M     = 26,
  parameter int N     = 14,
  parameter int STEPS = 1,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     in_dividend,
  input  logic [N-1:0]     in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M-1:0]     out_quotient,
  output logic [N-1:0]     out_remainder,
  output logic             out_div_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int c_stages = M / STEPS;

  if ((M % STEPS) != 0) begin : g_steps_check
    $error("divider_pipe: STEPS must divide M");
  end

  typedef struct packed {
    logic [M-1:0] q;
    logic [N-1:0] r;
    logic [M-1:0] x;
  } part_t;

  // STEPS restoring iterations; x holds the not-yet-consumed dividend bits, MSB first
  function automatic part_t f_step(input part_t a, input logic [N-1:0] d);
    part_t      o;
    logic [N:0] p;
    o = a;
    for (int s = 0; s < STEPS; s++) begin
      p   = {o.r, o.x[M-1]};
      o.x = {o.x[M-2:0], 1'b0};
      if (p >= {1'b0, d}) begin
        o.r = p[N-1:0] - d;
        o.q = {o.q[M-2:0], 1'b1};
      end else begin
        o.r = p[N-1:0];
        o.q = {o.q[M-2:0], 1'b0};
      end
    end
    return o;
  endfunction

  // Register 0 captures raw operands; registers 1..c_stages each resolve STEPS bits
  logic             r_v  [0:c_stages];
  logic [M-1:0]     r_q  [0:c_stages];
  logic [N-1:0]     r_r  [0:c_stages];
  logic             r_dz [0:c_stages];
  logic [TAG_W-1:0] r_t  [0:c_stages];
  logic [M-1:0]     r_x  [0:c_stages-1];
  logic [N-1:0]     r_d  [0:c_stages-1];
  part_t            w_nxt[0:c_stages-1];
  logic             w_adv;

  assign w_adv    = !r_v[c_stages] || out_ready;
  assign in_ready = w_adv;

  always_comb begin
    for (int s = 0; s < c_stages; s++) begin
      w_nxt[s] = f_step('{q: r_q[s], r: r_r[s], x: r_x[s]}, r_d[s]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s <= c_stages; s++) begin
        r_v[s]  <= 1'b0;
        r_q[s]  <= '0;
        r_r[s]  <= '0;
        r_dz[s] <= 1'b0;
        r_t[s]  <= '0;
      end
      for (int s = 0; s < c_stages; s++) begin
        r_x[s] <= '0;
        r_d[s] <= '0;
      end
    end else if (w_adv) begin
      r_v[0]  <= in_valid;
      r_q[0]  <= '0;
      r_r[0]  <= '0;
      r_x[0]  <= in_dividend;
      r_d[0]  <= in_divisor;
      r_dz[0] <= (in_divisor == '0);
      r_t[0]  <= in_tag;
      for (int s = 1; s <= c_stages; s++) begin
        r_v[s]  <= r_v[s-1];
        r_q[s]  <= w_nxt[s-1].q;
        r_r[s]  <= w_nxt[s-1].r;
        r_dz[s] <= r_dz[s-1];
        r_t[s]  <= r_t[s-1];
      end
      for (int s = 1; s < c_stages; s++) begin
        r_x[s] <= w_nxt[s-1].x;
        r_d[s] <= r_d[s-1];
      end
    end
  end

  assign out_valid     = r_v[c_stages];
  assign out_quotient  = r_q[c_stages];
  assign out_remainder = r_r[c_stages];
  assign out_div_zero  = r_dz[c_stages];
  assign out_tag       = r_t[c_stages];

endmodule

`default_nettype wire
